pipe_skid_reg: RTL and testbench
================================

# pipe_skid_reg

Parametrised pipeline-stage register that succeeds the fixed-field stall-vector stage registers between ID/EXE/MEM/WB. It carries an opaque payload of DATA_W bits using a valid/ready handshake instead of a global stall vector. A 2-entry skid buffer gives full throughput with a registered `in_ready`. A flush input kills all held entries, and flushed or empty slots present a configurable NOP payload. A saturating counter records downstream bubble cycles for performance analysis.

## Interface
- DATA_W, default 160: payload width in bits; any value ≥ 1.
- NOP_DATA, default {DATA_W{1'b0}}: payload driven while empty, after reset and after flush.
- CNT_W, default 16: bubble counter width; ≥ 1.

Ports:
- cpu_clk_50M  in  1  sole clock; all state updates on its rising edge.
- cpu_rst  in  1  synchronous, active-high reset.
- flush  in  1  kill all held entries (exception / branch redirect).
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept; registered, no combinational path from out_ready.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  out_data holds a live entry.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  head payload; equals NOP_DATA when out_valid=0.
- occupancy  out  2  live entries: 0, 1 or 2.
- bubble_cnt  out  CNT_W  saturating count of cycles with out_ready=1 and out_valid=0.

## Operation
- Storage: main register (head, drives out_data) and skid register.
- Handshake events: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States: EMPTY (occ 0), ONE (occ 1), FULL (occ 2).
- Outputs are decoded from state: in_ready = (state != FULL); out_valid = (state != EMPTY); occupancy = state encoding.
- Priority per edge: cpu_rst > flush > normal transitions.
- cpu_rst: state EMPTY; main and skid load NOP_DATA; bubble_cnt loads 0.
- flush (without reset):
  - state goes to EMPTY; main and skid load NOP_DATA.
  - Any same-cycle in_fire or out_fire is discarded.
  - bubble_cnt is not cleared.
- EMPTY:
  - in_fire → ONE, main <= in_data.
  - Otherwise hold.
- ONE:
  - in_fire & out_fire → ONE, main <= in_data.
  - in_fire & !out_fire → FULL, skid <= in_data.
  - !in_fire & out_fire → EMPTY, main <= NOP_DATA.
  - Otherwise hold.
- FULL (in_ready = 0, so in_valid is ignored):
  - out_fire → ONE, main <= skid, skid <= NOP_DATA.
  - Otherwise hold.
- bubble_cnt: when out_ready & !out_valid, it increments by 1 unless it equals 2^CNT_W−1, in which case it stays saturated. This rule is also evaluated on flush cycles, using the pre-flush out_valid.
- Payload is opaque; no field decoding. Upstream must hold in_data/in_valid stable while in_valid & !in_ready.
- Ordering is strict FIFO; no entry is duplicated or dropped except by flush/reset.

## Timing
- Latency: an accepted entry appears on out_data one cycle after in_fire when the stage is EMPTY, or ONE with a same-cycle out_fire.
- Throughput: 1 entry/cycle sustained while out_ready=1.
- in_ready deasserts the cycle after the stage reaches FULL, and reasserts the cycle after the out_fire that leaves FULL.
- While out_valid & !out_ready, out_data is stable across cycles.
- After reset or flush, out_valid=0 and out_data=NOP_DATA from the next cycle; in_ready=1 that same cycle.
- All outputs are registered or decoded from registered state only. The single exception is that the bubble_cnt increment condition samples out_ready combinationally; bubble_cnt itself is registered.
- Reset values: in_ready=1, out_valid=0, out_data=NOP_DATA, occupancy=0, bubble_cnt=0.

## Test plan
- **Reset then stream:** DATA_W=32. Assert cpu_rst 2 cycles, then drive A0..A7 back-to-back with out_ready=1 → out_data = A0..A7 on consecutive cycles, starting 1 cycle after the first in_fire. in_ready stays 1 and occupancy stays 1.
- **Backpressure fill:** send 0x11, 0x22, 0x33 with out_ready=0 → occupancy goes 1 then 2; in_ready=0 after 0x22; 0x33 is held upstream. Raise out_ready → out_data = 0x11, 0x22, 0x33 in order with no loss.
- **Flush while FULL:** hold 0x11/0x22 with out_ready=0, then assert flush together with in_valid (0x44) → next cycle occupancy=0, out_valid=0, out_data=NOP_DATA, and 0x44 is not captured.
- **Simultaneous in/out in ONE:** hold 0x55, then pulse in_valid (0x66) with out_ready=1 → occupancy stays 1 and out_data=0x66 the next cycle.
- **Bubble counter saturation:** CNT_W=3, out_ready=1, no input for 10 cycles → bubble_cnt goes 1..7 and stays at 7. A cpu_rst cycle returns it to 0; a flush does not.
- **Reset mid-operation:** while FULL with out_ready toggling, assert cpu_rst → next cycle all outputs equal their reset values, even if flush is also high.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
//
// Generic pipeline-stage register with a valid/ready handshake and a 2-entry
// skid buffer. The payload is opaque. in_ready is decoded from registered state
// only, so there is no combinational path from out_ready back to in_ready, and
// the stage still sustains one entry per cycle. A flush empties the stage.
// Empty slots hold NOP_DATA. A saturating counter records downstream bubble
// cycles.
//
// Parameters:
//   DATA_W   payload width in bits (>= 1)
//   NOP_DATA payload presented while empty, after reset and after flush
//   CNT_W    bubble counter width (>= 1)
//
// Ports:
//   cpu_clk_50M  in   sole clock, rising edge
//   cpu_rst      in   synchronous active-high reset
//   flush        in   discard all held entries
//   in_valid     in   upstream payload valid
//   in_ready     out  stage can accept (decoded from registered state)
//   in_data      in   upstream payload
//   out_valid    out  out_data holds a live entry
//   out_ready    in   downstream accepts this cycle
//   out_data     out  head payload, NOP_DATA when out_valid=0
//   occupancy    out  number of live entries (0..2)
//   bubble_cnt   out  saturating count of out_ready & !out_valid cycles
// -----------------------------------------------------------------------------
module pipe_skid_reg #(
   parameter int                 DATA_W   = 160,
   parameter logic [DATA_W-1:0]  NOP_DATA = {DATA_W{1'b0}},
   parameter int                 CNT_W    = 16
) (
   input  logic              cpu_clk_50M,
   input  logic              cpu_rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  bubble_cnt
);

   // State encoding equals the live-entry count, so occupancy is the state.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

   state_t              state_r;
   state_t              state_nx_s;
   logic [DATA_W-1:0]   main_r;
   logic [DATA_W-1:0]   main_nx_s;
   logic [DATA_W-1:0]   skid_r;
   logic [DATA_W-1:0]   skid_nx_s;
   logic [CNT_W-1:0]    bubble_cnt_r;
   logic                in_fire_s;
   logic                out_fire_s;
   logic                bubble_inc_s;

   assign in_ready   = (state_r != ST_FULL);
   assign out_valid  = (state_r != ST_EMPTY);
   assign occupancy  = state_r;
   assign out_data   = main_r;
   assign bubble_cnt = bubble_cnt_r;

   assign in_fire_s  = in_valid & in_ready;
   assign out_fire_s = out_valid & out_ready;

   // Uses the current (pre-flush) out_valid, so a flush cycle can still count.
   assign bubble_inc_s = out_ready & ~out_valid & (bubble_cnt_r != CNT_MAX);

   // Next-state and next-payload decode; flush overrides any handshake.
   always_comb begin
      state_nx_s = state_r;
      main_nx_s  = main_r;
      skid_nx_s  = skid_r;
      if (flush) begin
         state_nx_s = ST_EMPTY;
         main_nx_s  = NOP_DATA;
         skid_nx_s  = NOP_DATA;
      end else begin
         case (state_r)
            ST_EMPTY: begin
               if (in_fire_s) begin
                  state_nx_s = ST_ONE;
                  main_nx_s  = in_data;
               end else begin
                  state_nx_s = ST_EMPTY;
               end
            end
            ST_ONE: begin
               if (in_fire_s && out_fire_s) begin
                  state_nx_s = ST_ONE;
                  main_nx_s  = in_data;
               end else if (in_fire_s) begin
                  state_nx_s = ST_FULL;
                  skid_nx_s  = in_data;
               end else if (out_fire_s) begin
                  state_nx_s = ST_EMPTY;
                  main_nx_s  = NOP_DATA;
               end else begin
                  state_nx_s = ST_ONE;
               end
            end
            ST_FULL: begin
               // in_ready is low here, so only the drain side can move.
               if (out_fire_s) begin
                  state_nx_s = ST_ONE;
                  main_nx_s  = skid_r;
                  skid_nx_s  = NOP_DATA;
               end else begin
                  state_nx_s = ST_FULL;
               end
            end
            default: begin
               // Unreachable encoding: recover to a clean empty stage.
               state_nx_s = ST_EMPTY;
               main_nx_s  = NOP_DATA;
               skid_nx_s  = NOP_DATA;
            end
         endcase
      end
   end

   // State and payload registers with synchronous reset.
   always_ff @(posedge cpu_clk_50M) begin
      if (cpu_rst) begin
         state_r <= ST_EMPTY;
         main_r  <= NOP_DATA;
         skid_r  <= NOP_DATA;
      end else begin
         state_r <= state_nx_s;
         main_r  <= main_nx_s;
         skid_r  <= skid_nx_s;
      end
   end

   // Saturating bubble counter; cleared only by reset, never by flush.
   always_ff @(posedge cpu_clk_50M) begin
      if (cpu_rst) begin
         bubble_cnt_r <= {CNT_W{1'b0}};
      end else if (bubble_inc_s) begin
         bubble_cnt_r <= bubble_cnt_r + CNT_ONE;
      end else begin
         bubble_cnt_r <= bubble_cnt_r;
      end
   end

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

   localparam int               DATA_W = 32;
   localparam int               CNT_W  = 3;
   localparam logic [31:0]      NOP    = 32'hDEAD_BEEF;

   logic              cpu_clk_50M;
   logic              cpu_rst;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        occupancy;
   logic [CNT_W-1:0]  bubble_cnt;

   int errors = 0;
   int checks = 0;

   pipe_skid_reg #(
      .DATA_W   (DATA_W),
      .NOP_DATA (NOP),
      .CNT_W    (CNT_W)
   ) dut (
      .cpu_clk_50M (cpu_clk_50M),
      .cpu_rst     (cpu_rst),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .occupancy   (occupancy),
      .bubble_cnt  (bubble_cnt)
   );

   initial cpu_clk_50M = 1'b0;
   always #10 cpu_clk_50M = ~cpu_clk_50M;

   // Advance one clock; outputs are sampled 1 ns after the rising edge.
   task automatic step();
      @(posedge cpu_clk_50M);
      #1;
   endtask

   task automatic test_reset();
      cpu_rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 32'h0;
      step(); step();
      cpu_rst = 1'b0;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      checks++; if (out_data !== NOP) begin errors++; $display("FAIL reset_out_data got %h exp %h", out_data, NOP); end
      checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy got %0d exp 0", occupancy); end
      checks++; if (bubble_cnt !== 3'd0) begin errors++; $display("FAIL reset_bubble got %0d exp 0", bubble_cnt); end
   endtask

   task automatic test_stream();
      logic [31:0] exp_d;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 8; i++) begin
         exp_d   = 32'hA000_0000 + 32'(i);
         in_data = exp_d;
         step();
         checks++; if (out_data !== exp_d || out_valid !== 1'b1) begin errors++; $display("FAIL stream_data[%0d] got %h/%b exp %h/1", i, out_data, out_valid, exp_d); end
         checks++; if (in_ready !== 1'b1 || occupancy !== 2'd1) begin errors++; $display("FAIL stream_occ[%0d] got rdy=%b occ=%0d exp rdy=1 occ=1", i, in_ready, occupancy); end
      end
      in_valid = 1'b0;
      step();
      checks++; if (occupancy !== 2'd0 || out_data !== NOP) begin errors++; $display("FAIL stream_drain got occ=%0d data=%h exp 0/%h", occupancy, out_data, NOP); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'h11;
      step();
      checks++; if (occupancy !== 2'd1 || in_ready !== 1'b1 || out_data !== 32'h11) begin errors++; $display("FAIL bp_first got occ=%0d rdy=%b data=%h exp 1/1/11", occupancy, in_ready, out_data); end
      in_data = 32'h22;
      step();
      checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'h11) begin errors++; $display("FAIL bp_full got occ=%0d rdy=%b data=%h exp 2/0/11", occupancy, in_ready, out_data); end
      in_data = 32'h33;
      step();
      checks++; if (occupancy !== 2'd2 || out_data !== 32'h11) begin errors++; $display("FAIL bp_hold got occ=%0d data=%h exp 2/11", occupancy, out_data); end
      out_ready = 1'b1;
      step();
      checks++; if (out_data !== 32'h22 || occupancy !== 2'd1 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_drain1 got data=%h occ=%0d rdy=%b exp 22/1/1", out_data, occupancy, in_ready); end
      step();
      checks++; if (out_data !== 32'h33 || occupancy !== 2'd1) begin errors++; $display("FAIL bp_drain2 got data=%h occ=%0d exp 33/1", out_data, occupancy); end
      in_valid = 1'b0;
      step();
      checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== NOP) begin errors++; $display("FAIL bp_empty got occ=%0d vld=%b data=%h exp 0/0/%h", occupancy, out_valid, out_data, NOP); end
   endtask

   task automatic test_flush_full();
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'h11; step();
      in_data = 32'h22; step();
      checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL flush_prefill got occ=%0d exp 2", occupancy); end
      flush = 1'b1; in_data = 32'h44;
      step();
      flush = 1'b0; in_valid = 1'b0;
      checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== NOP || in_ready !== 1'b1) begin errors++; $display("FAIL flush_empty got occ=%0d vld=%b data=%h rdy=%b exp 0/0/%h/1", occupancy, out_valid, out_data, in_ready, NOP); end
      step();
      checks++; if (occupancy !== 2'd0 || out_data !== NOP) begin errors++; $display("FAIL flush_no_capture got occ=%0d data=%h exp 0/%h", occupancy, out_data, NOP); end
   endtask

   task automatic test_simul_one();
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'h55;
      step();
      checks++; if (out_data !== 32'h55 || occupancy !== 2'd1) begin errors++; $display("FAIL simul_hold got data=%h occ=%0d exp 55/1", out_data, occupancy); end
      in_data = 32'h66; out_ready = 1'b1;
      step();
      checks++; if (out_data !== 32'h66 || occupancy !== 2'd1) begin errors++; $display("FAIL simul_swap got data=%h occ=%0d exp 66/1", out_data, occupancy); end
      in_valid = 1'b0;
      step();
      checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL simul_drain got occ=%0d exp 0", occupancy); end
      out_ready = 1'b0;
   endtask

   task automatic test_bubble_sat();
      logic [2:0] exp_c;
      cpu_rst = 1'b1; step(); cpu_rst = 1'b0;
      checks++; if (bubble_cnt !== 3'd0) begin errors++; $display("FAIL bubble_clear got %0d exp 0", bubble_cnt); end
      out_ready = 1'b1; in_valid = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         step();
         exp_c = 3'(k);
         checks++; if (bubble_cnt !== exp_c) begin errors++; $display("FAIL bubble_inc[%0d] got %0d exp %0d", k, bubble_cnt, exp_c); end
      end
      // Flush cycle still counts (stage was empty) and does not clear.
      flush = 1'b1; step(); flush = 1'b0;
      checks++; if (bubble_cnt !== 3'd4) begin errors++; $display("FAIL bubble_flush_count got %0d exp 4", bubble_cnt); end
      cpu_rst = 1'b1; step(); cpu_rst = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         step();
         exp_c = (k > 7) ? 3'd7 : 3'(k);
         checks++; if (bubble_cnt !== exp_c) begin errors++; $display("FAIL bubble_sat[%0d] got %0d exp %0d", k, bubble_cnt, exp_c); end
      end
      flush = 1'b1; step(); flush = 1'b0;
      checks++; if (bubble_cnt !== 3'd7) begin errors++; $display("FAIL bubble_flush_keep got %0d exp 7", bubble_cnt); end
      cpu_rst = 1'b1; step(); cpu_rst = 1'b0;
      checks++; if (bubble_cnt !== 3'd0) begin errors++; $display("FAIL bubble_rst got %0d exp 0", bubble_cnt); end
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'h11; step();
      in_data = 32'h22; step();
      in_data = 32'h33; out_ready = 1'b1; step();
      checks++; if (out_data !== 32'h22 || occupancy !== 2'd1) begin errors++; $display("FAIL mid_toggle got data=%h occ=%0d exp 22/1", out_data, occupancy); end
      out_ready = 1'b0; step();
      checks++; if (occupancy !== 2'd2 || out_data !== 32'h22) begin errors++; $display("FAIL mid_refill got occ=%0d data=%h exp 2/22", occupancy, out_data); end
      cpu_rst = 1'b1; flush = 1'b1; out_ready = 1'b1; in_data = 32'h77;
      step();
      cpu_rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL mid_rst_ctrl got rdy=%b vld=%b occ=%0d exp 1/0/0", in_ready, out_valid, occupancy); end
      checks++; if (out_data !== NOP || bubble_cnt !== 3'd0) begin errors++; $display("FAIL mid_rst_data got data=%h cnt=%0d exp %h/0", out_data, bubble_cnt, NOP); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_flush_full();
      test_simul_one();
      test_bubble_sat();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
